// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the CPU data-memory interface.
// Takes one request at a time and performs read-modify-write for sub-word stores.
// Sub-word loads are extracted from the memory word and sign- or zero-extended.
module load_store_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_signed,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic [31:0] o_mem_a,
    output logic [31:0] o_mem_wd,
    output logic        o_mem_we,
    input  logic [31:0] i_mem_rd
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e      r_state;
    state_e      w_state_d;

    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_write;
    logic        r_signed;
    logic [31:0] r_wdata;
    logic [31:0] r_rbuf;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    // Misaligned or illegal-size request, judged on the incoming request.
    always_comb begin
        w_req_err = 1'b0;
        case (i_req_size)
            2'b01:   w_req_err = i_req_addr[0];
            2'b10:   w_req_err = (i_req_addr[1:0] != 2'b00);
            2'b11:   w_req_err = 1'b1;
            default: w_req_err = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    if (w_req_err) begin
                        w_state_d = StResp;
                    end else if (i_req_write && (i_req_size == 2'b10)) begin
                        w_state_d = StWrite;
                    end else begin
                        w_state_d = StRead;
                    end
                end
            end
            StRead:  w_state_d = r_write ? StWrite : StResp;
            StWrite: w_state_d = StResp;
            StResp:  if (i_resp_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Load extraction works on the live read word so the result can be registered in READ.
    always_comb begin
        w_byte = i_mem_rd[{r_addr[1:0], 3'b000} +: 8];
        w_half = i_mem_rd[{r_addr[1], 4'b0000} +: 16];
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = i_mem_rd;
        endcase
    end

    // Store merge: replace the addressed lane of the buffered read word.
    always_comb begin
        w_merged = r_rbuf;
        case (r_size)
            2'b00:   w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            2'b01:   w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            default: w_merged = r_wdata;
        endcase
    end

    // State register and request/response datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_addr   <= '0;
            r_size   <= '0;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_wdata  <= '0;
            r_rbuf   <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if ((r_state == StIdle) && i_req_valid) begin
                r_addr   <= i_req_addr;
                r_size   <= i_req_size;
                r_write  <= i_req_write;
                r_signed <= i_req_signed;
                r_wdata  <= i_req_wdata;
                r_err    <= w_req_err;
                r_rdata  <= '0;
            end
            if (r_state == StRead) begin
                r_rbuf <= i_mem_rd;
                if (!r_write) r_rdata <= w_load;
            end
        end
    end

    // Outputs decoded from state; mem_we falls as soon as reset clears the state.
    always_comb begin
        o_req_ready  = (r_state == StIdle);
        o_resp_valid = (r_state == StResp);
        o_mem_we     = (r_state == StWrite);
        o_mem_wd     = (r_state == StWrite) ? w_merged : 32'h0;
        o_mem_a      = {2'b00, r_addr[31:2]};
        o_resp_rdata = r_rdata;
        o_resp_err   = r_err;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a word-addressed memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem [64];
    int          checks;
    int          errors;
    int          we_total;

    load_store_unit u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_write  (req_write),
        .i_req_size   (req_size),
        .i_req_signed (req_signed),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err),
        .o_mem_a      (mem_a),
        .o_mem_wd     (mem_wd),
        .o_mem_we     (mem_we),
        .i_mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word i = 2*i on reset, synchronous write, combinational read.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 64; k++) mem[k] <= 32'(2 * k);
        end else if (mem_we) begin
            mem[mem_a[5:0]] <= mem_wd;
        end
    end
    assign mem_rd = mem[mem_a[5:0]];

    always @(posedge clk) if (mem_we) we_total <= we_total + 1;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one request with resp_ready held high and check the whole transaction.
    task automatic run_vec(input vec_t v, input int idx);
        int          n;
        int          we_cnt;
        logic [31:0] wd_seen;
        @(negedge clk);
        chk($sformatf("v%0d req_ready before", idx), 32'(req_ready), 32'd1);
        req_write  = v.wr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n         = 1;
        we_cnt    = 0;
        wd_seen   = 32'h0;
        chk($sformatf("v%0d mem_a", idx), mem_a, {2'b00, v.addr[31:2]});
        while (!resp_valid && n < 8) begin
            if (mem_we) begin
                we_cnt++;
                wd_seen = mem_wd;
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("v%0d latency", idx), 32'(n), 32'(v.exp_lat));
        chk($sformatf("v%0d resp_rdata", idx), resp_rdata, v.exp_rdata);
        chk($sformatf("v%0d resp_err", idx), 32'(resp_err), 32'(v.exp_err));
        chk($sformatf("v%0d we pulses", idx), 32'(we_cnt), 32'(v.exp_we));
        if (v.exp_we != 0) chk($sformatf("v%0d mem_wd", idx), wd_seen, v.exp_wd);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d idle after accept", idx), {30'h0, req_ready, resp_valid}, 32'h2);
    endtask

    initial begin
        int n;
        int we_base;
        vec_t v;
        checks     = 0;
        errors     = 0;
        we_total   = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;

        //          wr    size   sgn   addr     wdata         rdata         err lat we wd
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        32'h0000000A, 1'b0, 2, 0, 32'h0};
        vecs[1]  = '{1'b1, 2'b00, 1'b0, 32'h0D, 32'h000000FF, 32'h0,        1'b0, 3, 1, 32'h0000FF06};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h0D, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 0, 32'h0};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h0D, 32'h0,        32'h000000FF, 1'b0, 2, 0, 32'h0};
        vecs[4]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 32'h0,        1'b0, 3, 1, 32'h80010008};
        vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'hFFFF8001, 1'b0, 2, 0, 32'h0};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'h00000008, 1'b0, 2, 0, 32'h0};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 32'h0,        1'b0, 2, 1, 32'h12345678};
        vecs[8]  = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'h12345678, 1'b0, 2, 0, 32'h0};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h02, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h05, 32'h0000BEEF, 32'h0,        1'b1, 1, 0, 32'h0};
        vecs[11] = '{1'b0, 2'b11, 1'b0, 32'h08, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
        vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0, 32'h0};
        vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h00008001, 1'b0, 2, 0, 32'h0};

        #12;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset mem_wd", mem_wd, 32'h0);
        chk("reset mem_a", mem_a, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // Error requests must leave memory untouched.
        chk("mem word1 after errors", mem[1], 32'h2);
        chk("mem word2 after errors", mem[2], 32'h4);

        // Response backpressure with req_valid held high.
        resp_ready = 1'b0;
        @(negedge clk);
        req_write  = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h14;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        n = 1;
        while (!resp_valid && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp latency", 32'(n), 32'd2);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp hold%0d resp_valid", c), 32'(resp_valid), 32'd1);
            chk($sformatf("bp hold%0d resp_rdata", c), resp_rdata, 32'h0000000A);
            chk($sformatf("bp hold%0d req_ready", c), 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp released idle", {30'h0, req_ready, resp_valid}, 32'h2);
        @(posedge clk);
        #1;
        chk("bp new req accepted", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp second resp_rdata", resp_rdata, 32'h0000000A);
        @(posedge clk);
        #1;

        // Reset asserted during the READ of a byte store.
        @(negedge clk);
        req_write  = 1'b1;
        req_size   = 2'b00;
        req_addr   = 32'h04;
        req_wdata  = 32'h00000055;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        we_base   = we_total;
        chk("rst in READ req_ready", 32'(req_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst no we pulse", 32'(we_total - we_base), 32'd0);
        chk("rst target word", mem[1], 32'h2);
        v = '{1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 32'h00000002, 1'b0, 2, 0, 32'h0};
        run_vec(v, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
